// File: rtl/clk_loop_pkg.sv
// Shared definitions for the MMCM reset/lock supervisor.
// State encodings, state width and a counter-width helper.
package clk_loop_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Minimum width 1 so single-cycle parameters still get a counter.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/clk_loop_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
// Async active-low clear; flops tagged ASYNC_REG for placement.
module clk_loop_sync
  import clk_loop_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_loop_rst_ctrl.sv
// MMCM reset/lock supervisor on the free-running input clock.
// Optional lock-loss counter: define CLK_LOOP_LOCK_LOSS_CNT_EN.
module clk_loop_rst_ctrl
  import clk_loop_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 200000,
  parameter int STABLE_CYC       = 4096,
  parameter int MAX_RETRY        = 3,
  parameter int SYNC_STAGES      = 2
) (
  input  logic        clk_gloal_in,
  input  logic        hardware_rst_n_in,
  input  logic        mmcm_locked_in,
  input  logic        retry_req_in,
  output logic        mmcm_rst_out,
  output logic        logic_rst_n_out,
  output logic        clk_ready_out,
  output logic        fault_out,
  output logic [3:0]  retry_cnt_out,
  output logic [15:0] lock_loss_cnt_out,
  output logic [2:0]  state_out
);

  localparam int PULSE_W = clog2(RST_PULSE_CYC);
  localparam int TMO_W   = clog2(LOCK_TIMEOUT_CYC);
  localparam int STAB_W  = clog2(STABLE_CYC);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(STABLE_CYC - 1);

  state_t             r_state;
  state_t             w_nxt;
  logic [PULSE_W-1:0] r_pulse_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [STAB_W-1:0]  r_stab_cnt;
  logic [3:0]         r_retry_cnt;
  logic [3:0]         w_retry_inc;
  logic               w_locked_s;
  logic               w_tmo;
  logic               w_fail;
  logic               w_clr_retry;
  logic               w_in_lock;
  logic               w_stay_lock;
  logic               r_mmcm_rst;
  logic               r_logic_rst_n;
  logic               r_ready;
  logic               r_fault;

  clk_loop_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk_gloal_in),
    .i_rst_n (hardware_rst_n_in),
    .i_d     (mmcm_locked_in),
    .o_q     (w_locked_s)
  );

  assign w_tmo       = (r_tmo_cnt == TMO_LAST);
  assign w_retry_inc = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;

  // Stable completion is checked before timeout, timeout before lock drop.
  always_comb begin
    w_nxt  = r_state;
    w_fail = 1'b0;
    unique case (r_state)
      ST_RST: begin
        if (r_pulse_cnt == PULSE_LAST) w_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_tmo) begin
          w_fail = 1'b1;
          w_nxt  = (w_retry_inc >= 4'(MAX_RETRY)) ? ST_FAULT : ST_RST;
        end else if (w_locked_s) begin
          w_nxt = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (w_locked_s && (r_stab_cnt == STAB_LAST)) begin
          w_nxt = ST_RUN;
        end else if (w_tmo) begin
          w_fail = 1'b1;
          w_nxt  = (w_retry_inc >= 4'(MAX_RETRY)) ? ST_FAULT : ST_RST;
        end else if (!w_locked_s) begin
          w_nxt = ST_WAIT_LOCK;
        end
      end
      ST_RUN: begin
        if (!w_locked_s) w_nxt = ST_RST;
      end
      ST_FAULT: begin
        if (retry_req_in) w_nxt = ST_RST;
      end
      default: w_nxt = ST_RST;
    endcase
  end

  assign w_in_lock   = (r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE);
  assign w_stay_lock = w_in_lock &&
                       ((w_nxt == ST_WAIT_LOCK) || (w_nxt == ST_STABLE));
  assign w_clr_retry = (w_nxt == ST_RUN) ||
                       ((r_state == ST_FAULT) && (w_nxt == ST_RST));

  always_ff @(posedge clk_gloal_in or negedge hardware_rst_n_in) begin
    if (!hardware_rst_n_in) begin
      r_state       <= ST_RST;
      r_pulse_cnt   <= '0;
      r_tmo_cnt     <= '0;
      r_stab_cnt    <= '0;
      r_retry_cnt   <= '0;
      r_mmcm_rst    <= 1'b1;
      r_logic_rst_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_pulse_cnt   <= ((r_state == ST_RST) && (w_nxt == ST_RST)) ?
                       r_pulse_cnt + 1'b1 : '0;
      r_tmo_cnt     <= w_stay_lock ? r_tmo_cnt + 1'b1 : '0;
      r_stab_cnt    <= ((r_state == ST_STABLE) && (w_nxt == ST_STABLE)) ?
                       r_stab_cnt + 1'b1 : '0;
      if (w_fail)           r_retry_cnt <= w_retry_inc;
      else if (w_clr_retry) r_retry_cnt <= '0;
      r_mmcm_rst    <= (w_nxt == ST_RST) || (w_nxt == ST_FAULT);
      r_logic_rst_n <= (w_nxt == ST_RUN);
      r_ready       <= (w_nxt == ST_RUN);
      r_fault       <= (w_nxt == ST_FAULT);
    end
  end

`ifdef CLK_LOOP_LOCK_LOSS_CNT_EN
  logic        w_lock_loss;
  logic [15:0] r_loss_cnt;

  assign w_lock_loss = (r_state == ST_RUN) && (w_nxt == ST_RST);

  always_ff @(posedge clk_gloal_in or negedge hardware_rst_n_in) begin
    if (!hardware_rst_n_in)
      r_loss_cnt <= '0;
    else if (w_lock_loss && (r_loss_cnt != 16'hFFFF))
      r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign lock_loss_cnt_out = r_loss_cnt;
`else
  assign lock_loss_cnt_out = 16'h0000;
`endif

  assign mmcm_rst_out    = r_mmcm_rst;
  assign logic_rst_n_out = r_logic_rst_n;
  assign clk_ready_out   = r_ready;
  assign fault_out       = r_fault;
  assign retry_cnt_out   = r_retry_cnt;
  assign state_out       = r_state;

endmodule

// File: tb/tb_clk_loop_rst_ctrl.sv
// Bench for clk_loop_rst_ctrl: per-cycle model compare plus
// hand-computed timing pins for lock, retry, fault and reset paths.
module tb_clk_loop_rst_ctrl;

  localparam int P  = 4;
  localparam int T  = 100;
  localparam int S  = 16;
  localparam int MR = 3;
  localparam int NS = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        locked = 1'b0;
  logic        rreq  = 1'b0;
  logic        mmcm_rst;
  logic        lrst_n;
  logic        ready;
  logic        fault;
  logic [3:0]  rcnt;
  logic [15:0] lcnt;
  logic [2:0]  st;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  clk_loop_rst_ctrl #(
    .RST_PULSE_CYC    (P),
    .LOCK_TIMEOUT_CYC (T),
    .STABLE_CYC       (S),
    .MAX_RETRY        (MR),
    .SYNC_STAGES      (NS)
  ) dut (
    .clk_gloal_in      (clk),
    .hardware_rst_n_in (rst_n),
    .mmcm_locked_in    (locked),
    .retry_req_in      (rreq),
    .mmcm_rst_out      (mmcm_rst),
    .logic_rst_n_out   (lrst_n),
    .clk_ready_out     (ready),
    .fault_out         (fault),
    .retry_cnt_out     (rcnt),
    .lock_loss_cnt_out (lcnt),
    .state_out         (st)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus elapsed-edge counts since each phase began.
  int   m_st, m_rst_e, m_wait, m_run, m_retry, m_loss;
  logic m_sync [NS];
  logic m_ls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_rst_e = 0; m_wait = 0; m_run = 0;
      m_retry = 0; m_loss = 0;
      for (int i = 0; i < NS; i++) m_sync[i] = 1'b0;
    end else begin
      m_ls = m_sync[NS-1];
      case (m_st)
        0: begin
          m_rst_e++;
          if (m_rst_e == P) begin m_st = 1; m_wait = 0; end
        end
        1, 2: begin
          m_wait++;
          if (m_st == 2 && m_ls) m_run++;
          if (m_st == 2 && m_ls && m_run == S + 1) begin
            m_st = 3; m_retry = 0;
          end else if (m_wait == T) begin
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            m_st = (m_retry >= MR) ? 4 : 0;
            m_rst_e = 0;
          end else if (m_st == 1 && m_ls) begin
            m_st = 2; m_run = 1;
          end else if (m_st == 2 && !m_ls) begin
            m_st = 1;
          end
        end
        3: if (!m_ls) begin
          m_st = 0; m_rst_e = 0;
          if (m_loss < 65535) m_loss++;
        end
        4: if (rreq) begin m_st = 0; m_retry = 0; m_rst_e = 0; end
        default: m_st = 0;
      endcase
      for (int i = NS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = locked;
    end
  end

  function automatic int exp_loss();
`ifdef CLK_LOOP_LOCK_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state",  st,       m_st);
      chk("m_mmcm",   mmcm_rst, (m_st == 0 || m_st == 4));
      chk("m_lrst_n", lrst_n,   (m_st == 3));
      chk("m_ready",  ready,    (m_st == 3));
      chk("m_fault",  fault,    (m_st == 4));
      chk("m_retry",  rcnt,     m_retry);
      chk("m_loss",   lcnt,     exp_loss());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int e;
    int n;
    int seq[$];
    int prev;
    bit sawrun;
    int loss1;

`ifdef CLK_LOOP_LOCK_LOSS_CNT_EN
    loss1 = 1;
`else
    loss1 = 0;
`endif

    #1 rst_n = 1'b0;
    #1;
    chk("rst_mmcm", mmcm_rst, 1);
    chk("rst_lrst", lrst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_state", st, 0);
    chk("rst_retry", rcnt, 0);
    chk("rst_loss", lcnt, 0);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pulse width and lock-to-run latency
    cnt = 0;
    while (mmcm_rst === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("t1_pulse", cnt, 4);
    repeat (10) @(negedge clk);
    locked = 1'b1;
    e = 0;
    do begin
      @(posedge clk);
      #1;
      e++;
    end while (lrst_n !== 1'b1 && e < 40);
    chk("t1_latency", e, 19);
    chk("t1_ready", ready, 1);
    chk("t1_retry", rcnt, 0);

    // 3: one-cycle lock drop in RUN
    @(negedge clk);
    locked = 1'b0;
    @(posedge clk); #1;
    chk("t3_e1", lrst_n, 1);
    @(negedge clk);
    locked = 1'b1;
    @(posedge clk); #1;
    chk("t3_e2", lrst_n, 1);
    @(posedge clk); #1;
    chk("t3_e3", lrst_n, 0);
    chk("t3_loss", lcnt, loss1);
    @(negedge clk);
    cnt = 0;
    while (mmcm_rst === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("t3_pulse", cnt, 4);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_relock", ready, 1);

    // 2: no lock -> three attempts then FAULT; stray retry ignored
    @(negedge clk);
    locked = 1'b0;
    prev = 0;
    n = 0;
    while (fault !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (int'(rcnt) != prev) begin
        prev = int'(rcnt);
        seq.push_back(prev);
      end
      if (n == 20) rreq = 1'b1;
      else if (n == 21) rreq = 1'b0;
    end
    chk("t2_nseq", seq.size(), 3);
    chk("t2_seq0", seq[0], 1);
    chk("t2_seq1", seq[1], 2);
    chk("t2_seq2", seq[2], 3);
    chk("t2_state", st, 4);
    chk("t2_mmcm", mmcm_rst, 1);
    repeat (20) @(negedge clk);
    chk("t2_hold", fault, 1);
    rreq = 1'b1;
    @(negedge clk);
    rreq = 1'b0;
    chk("t2_rq_state", st, 0);
    chk("t2_rq_fault", fault, 0);
    chk("t2_rq_retry", rcnt, 0);

    // 4: lock chatter still times out: 3 x (4 + 100) edges
    sawrun = 0;
    n = 0;
    while (fault !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (n % 10 == 0) locked = ~locked;
      if (ready === 1'b1) sawrun = 1;
    end
    chk("t4_edges", n, 312);
    chk("t4_norun", sawrun, 0);
    chk("t4_retry", rcnt, 3);

    // 5: stable completes exactly on the timeout edge
    rreq = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    rreq = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k == 85) locked = 1'b1;
      if (k == 103) chk("t5_pre", st, 2);
      if (k == 104) begin
        chk("t5_state", st, 3);
        chk("t5_retry", rcnt, 0);
        chk("t5_ready", ready, 1);
      end
    end

    // 6: async reset in STABLE
    locked = 1'b0;
    repeat (5) @(negedge clk);
    locked = 1'b1;
    n = 0;
    while (st !== 3'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t6_pre", st, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mmcm", mmcm_rst, 1);
    chk("t6_state", st, 0);
    chk("t6_retry", rcnt, 0);
    chk("t6_loss", lcnt, 0);
    chk("t6_lrst", lrst_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_run", ready, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
